// File: rtl/reg_pkg.sv
// Shared definitions for the FunSel register bank.
//   fun_sel_e  : operation codes, named by what they do to a register
//   step_t     : result of one register step (next value, wrap set/clear)
//   reg_step() : computes the next value and wrap condition for a register
//                of 'width' bits (width <= MAX_WIDTH, even, >= 4)
package reg_pkg;

    typedef enum logic [2:0] {
        FS_DEC      = 3'b000,
        FS_INC      = 3'b001,
        FS_LOAD     = 3'b010,
        FS_CLR      = 3'b011,
        FS_WLO_CLR  = 3'b100,
        FS_WLO      = 3'b101,
        FS_WHI      = 3'b110,
        FS_WLO_SEXT = 3'b111
    } fun_sel_e;

    // Widest register the shared step function supports.
    localparam int MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t next;
        logic  wrap_set;
        logic  wrap_clr;
    } step_t;

    // Operands arrive zero-extended to MAX_WIDTH; the result is masked back to
    // 'width' bits so the caller can take the low slice. 'width' is always an
    // elaboration-time constant, so the masks fold away in synthesis.
    function automatic step_t reg_step(
        input word_t    q,
        input word_t    i,
        input fun_sel_e fs,
        input int       width
    );
        step_t r;
        word_t mask;
        word_t lo_mask;
        word_t hi_mask;
        word_t i_lo;
        int    half;

        half    = width / 2;
        mask    = (width >= MAX_WIDTH) ? '1 : ((word_t'(1) << width) - word_t'(1));
        lo_mask = (word_t'(1) << half) - word_t'(1);
        hi_mask = mask & ~lo_mask;
        i_lo    = i & lo_mask;

        r.next     = '0;
        r.wrap_set = 1'b0;
        r.wrap_clr = 1'b0;

        case (fs)
            FS_DEC: begin
                r.next     = (q - word_t'(1)) & mask;
                r.wrap_set = ((q & mask) == '0);
            end
            FS_INC: begin
                r.next     = (q + word_t'(1)) & mask;
                r.wrap_set = ((q & mask) == mask);
            end
            FS_LOAD:     r.next = i & mask;
            FS_CLR: begin
                r.next     = '0;
                r.wrap_clr = 1'b1;
            end
            FS_WLO_CLR:  r.next = i_lo;
            FS_WLO:      r.next = (q & hi_mask) | i_lo;
            // Low half of I lands in the high half of Q.
            FS_WHI:      r.next = (i_lo << half) | (q & lo_mask);
            FS_WLO_SEXT: r.next = i[half-1] ? (hi_mask | i_lo) : i_lo;
            default:     r.next = q & mask;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_cell.sv
// One FunSel register with its sticky wrap flag and zero detect.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   en           : perform fun_sel this cycle
//   fun_sel      : operation code (see reg_pkg::fun_sel_e)
//   din          : write data
//   q            : stored register value
//   wrap         : sticky flag, set on inc/dec wrap-around, cleared by FS_CLR
//   zero         : q == 0
module reg_cell
    import reg_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic [2:0]       fun_sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             zero
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    step_t            step;
    word_t            next_full;

    always_comb begin
        step      = reg_step(word_t'(q_reg), word_t'(din), fun_sel_e'(fun_sel), WIDTH);
        next_full = step.next;
        q_next    = q_reg;
        wrap_next = wrap_reg;
        if (en) begin
            q_next = next_full[WIDTH-1:0];
            // Set and clear never coincide: they come from different codes.
            if (step.wrap_set) begin
                wrap_next = 1'b1;
            end else if (step.wrap_clr) begin
                wrap_next = 1'b0;
            end
        end
    end

    // The step result is masked to WIDTH bits; the upper bits are always zero.
    generate
        if (WIDTH < MAX_WIDTH) begin : g_spare
            logic unused_hi;
            assign unused_hi = |next_full[MAX_WIDTH-1:WIDTH];
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_reg    <= RESET_VALUE;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    assign q    = q_reg;
    assign wrap = wrap_reg;
    assign zero = (q_reg == '0);

endmodule

// File: rtl/reg_bank.sv
// Parametrised FunSel register bank: NUM_REGS registers of WIDTH bits, each
// enabled register performs the shared FunSel operation on the clock edge.
//   Clock, Reset     : rising-edge clock, synchronous active-high reset
//   E                : per-register operation enable
//   FunSel           : operation code shared by all enabled registers
//   I                : write data
//   OutASel, OutBSel : read-port selects (combinational, no write-through)
//   OutA, OutB       : selected register contents
//   Wrap             : per-register sticky wrap flags
//   Zero             : per-register zero flags
module reg_bank
    import reg_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NUM_REGS    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              SEL_W       = $clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [NUM_REGS-1:0] E,
    input  logic [2:0]          FunSel,
    input  logic [WIDTH-1:0]    I,
    input  logic [SEL_W-1:0]    OutASel,
    input  logic [SEL_W-1:0]    OutBSel,
    output logic [WIDTH-1:0]    OutA,
    output logic [WIDTH-1:0]    OutB,
    output logic [NUM_REGS-1:0] Wrap,
    output logic [NUM_REGS-1:0] Zero
);

    logic [WIDTH-1:0] q_all [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
            reg_cell #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_cell (
                .Clock   (Clock),
                .Reset   (Reset),
                .en      (E[gi]),
                .fun_sel (FunSel),
                .din     (I),
                .q       (q_all[gi]),
                .wrap    (Wrap[gi]),
                .zero    (Zero[gi])
            );
        end
    endgenerate

    // Selects beyond NUM_REGS-1 (non power-of-two banks) read as zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OutASel == SEL_W'(k)) begin
                OutA = q_all[k];
            end
            if (OutBSel == SEL_W'(k)) begin
                OutB = q_all[k];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a 16-bit x 4 instance checked against a
// behavioural model, and an 8-bit x 8 instance checked against fixed values.
module tb_reg_bank;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    // 16-bit, 4-register instance
    logic        Reset;
    logic [3:0]  E;
    logic [2:0]  FunSel;
    logic [15:0] I;
    logic [1:0]  OutASel, OutBSel;
    logic [15:0] OutA, OutB;
    logic [3:0]  Wrap, Zero;

    // 8-bit, 8-register instance
    logic       reset8;
    logic [7:0] e8;
    logic [2:0] fs8;
    logic [7:0] i8;
    logic [2:0] sela8, selb8;
    logic [7:0] outa8, outb8;
    logic [7:0] wrap8, zero8;

    reg_bank #(.WIDTH(16), .NUM_REGS(4), .RESET_VALUE(16'h0000)) dut16 (
        .Clock(Clock), .Reset(Reset), .E(E), .FunSel(FunSel), .I(I),
        .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB),
        .Wrap(Wrap), .Zero(Zero)
    );

    reg_bank #(.WIDTH(8), .NUM_REGS(8), .RESET_VALUE(8'h00)) dut8 (
        .Clock(Clock), .Reset(reset8), .E(e8), .FunSel(fs8), .I(i8),
        .OutASel(sela8), .OutBSel(selb8), .OutA(outa8), .OutB(outb8),
        .Wrap(wrap8), .Zero(zero8)
    );

    typedef struct {
        string       tag;
        int          inst;
        int          idx;
        logic [15:0] val;
        logic [7:0]  wrap;
        logic [7:0]  zero;
    } exp_t;

    exp_t sb[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference state for the 16-bit instance
    logic [15:0] m_q [4];
    logic [3:0]  m_wrap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model16(input logic [15:0] q, input logic [15:0] i,
                                            input logic [2:0] fs);
        case (fs)
            3'd0:    return q - 16'd1;
            3'd1:    return q + 16'd1;
            3'd2:    return i;
            3'd3:    return 16'h0000;
            3'd4:    return {8'h00, i[7:0]};
            3'd5:    return {q[15:8], i[7:0]};
            3'd6:    return {i[7:0], q[7:0]};
            default: return {{8{i[7]}}, i[7:0]};
        endcase
    endfunction

    function automatic logic [3:0] zero_model();
        logic [3:0] z;
        for (int k = 0; k < 4; k++) z[k] = (m_q[k] == 16'h0000);
        return z;
    endfunction

    task automatic push16(input string tag, input int idx);
        exp_t x;
        x.tag  = tag;
        x.inst = 0;
        x.idx  = idx;
        x.val  = m_q[idx];
        x.wrap = {4'b0000, m_wrap};
        x.zero = {4'b0000, zero_model()};
        sb.push_back(x);
    endtask

    task automatic push8(input string tag, input int idx, input logic [7:0] val,
                         input logic [7:0] wrap, input logic [7:0] zero);
        exp_t x;
        x.tag  = tag;
        x.inst = 1;
        x.idx  = idx;
        x.val  = {8'h00, val};
        x.wrap = wrap;
        x.zero = zero;
        sb.push_back(x);
    endtask

    // Pop every pending expectation and compare against the selected register.
    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.inst == 0) begin
                OutASel = x.idx[1:0];
                OutBSel = x.idx[1:0];
                #1;
                $display("txn %-14s w16 R%0d A=%h B=%h Wrap=%b Zero=%b", x.tag, x.idx,
                         OutA, OutB, Wrap, Zero);
                check_eq({x.tag, ".A"}, {16'h0, OutA}, {16'h0, x.val});
                check_eq({x.tag, ".B"}, {16'h0, OutB}, {16'h0, x.val});
                check_eq({x.tag, ".wrap"}, {28'h0, Wrap}, {24'h0, x.wrap});
                check_eq({x.tag, ".zero"}, {28'h0, Zero}, {24'h0, x.zero});
            end else begin
                sela8 = x.idx[2:0];
                selb8 = x.idx[2:0];
                #1;
                $display("txn %-14s w8  R%0d A=%h B=%h Wrap=%b Zero=%b", x.tag, x.idx,
                         outa8, outb8, wrap8, zero8);
                check_eq({x.tag, ".A"}, {24'h0, outa8}, {24'h0, x.val[7:0]});
                check_eq({x.tag, ".B"}, {24'h0, outb8}, {24'h0, x.val[7:0]});
                check_eq({x.tag, ".wrap"}, {24'h0, wrap8}, {24'h0, x.wrap});
                check_eq({x.tag, ".zero"}, {24'h0, zero8}, {24'h0, x.zero});
            end
        end
    endtask

    // One operation on the 16-bit instance. Before the edge the watched
    // register must still show its old value (no write-through).
    task automatic op16(input string tag, input logic [3:0] e, input logic [2:0] fs,
                        input logic [15:0] i, input logic rst, input int watch,
                        input logic has_plan, input logic [15:0] plan);
        logic [15:0] old_q;
        @(negedge Clock);
        E       = e;
        FunSel  = fs;
        I       = i;
        Reset   = rst;
        OutASel = watch[1:0];
        old_q   = m_q[watch];
        #1;
        check_eq({tag, ".old"}, {16'h0, OutA}, {16'h0, old_q});
        if (rst) begin
            for (int k = 0; k < 4; k++) m_q[k] = 16'h0000;
            m_wrap = 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (e[k]) begin
                    if (fs == 3'd0 && m_q[k] == 16'h0000) m_wrap[k] = 1'b1;
                    if (fs == 3'd1 && m_q[k] == 16'hFFFF) m_wrap[k] = 1'b1;
                    if (fs == 3'd3) m_wrap[k] = 1'b0;
                    m_q[k] = model16(m_q[k], i, fs);
                end
            end
        end
        push16(tag, watch);
        @(posedge Clock);
        #1;
        E     = 4'b0000;
        Reset = 1'b0;
        drain();
        if (has_plan) begin
            OutASel = watch[1:0];
            #1;
            check_eq({tag, ".plan"}, {16'h0, OutA}, {16'h0, plan});
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] e, input logic [2:0] fs,
                       input logic [7:0] i, input logic rst, input int watch,
                       input logic [7:0] val, input logic [7:0] wrap, input logic [7:0] zero);
        @(negedge Clock);
        e8     = e;
        fs8    = fs;
        i8     = i;
        reset8 = rst;
        push8(tag, watch, val, wrap, zero);
        @(posedge Clock);
        #1;
        e8     = 8'h00;
        reset8 = 1'b0;
        drain();
    endtask

    initial begin
        Reset = 1'b1; E = 4'b0000; FunSel = 3'd0; I = 16'h0000; OutASel = 2'd0; OutBSel = 2'd0;
        reset8 = 1'b1; e8 = 8'h00; fs8 = 3'd0; i8 = 8'h00; sela8 = 3'd0; selb8 = 3'd0;
        for (int k = 0; k < 4; k++) m_q[k] = 16'h0000;
        m_wrap = 4'b0000;

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) push16("reset", k);
        drain();
        check_eq("reset.zero_all", {28'h0, Zero}, 32'hF);
        check_eq("reset.wrap_all", {28'h0, Wrap}, 32'h0);

        // Decrement wraps, clear drops the flag
        op16("dec_wrap", 4'b0001, 3'd0, 16'h0000, 1'b0, 0, 1'b1, 16'hFFFF);
        check_eq("dec_wrap.flag", {31'h0, Wrap[0]}, 32'h1);
        op16("clr", 4'b0001, 3'd3, 16'h0000, 1'b0, 0, 1'b1, 16'h0000);
        check_eq("clr.flag", {31'h0, Wrap[0]}, 32'h0);

        // Half-word writes on R1
        op16("load_r1", 4'b0010, 3'd2, 16'h1234, 1'b0, 1, 1'b1, 16'h1234);
        op16("wlo", 4'b0010, 3'd5, 16'hAB80, 1'b0, 1, 1'b1, 16'h1280);
        op16("whi", 4'b0010, 3'd6, 16'hAB80, 1'b0, 1, 1'b1, 16'h8080);
        op16("wlo_sext", 4'b0010, 3'd7, 16'hAB80, 1'b0, 1, 1'b1, 16'hFF80);
        op16("wlo_clr", 4'b0010, 3'd4, 16'hAB80, 1'b0, 1, 1'b1, 16'h0080);

        // Broadcast load, then increment a subset
        op16("load_all", 4'b1111, 3'd2, 16'h00FF, 1'b0, 3, 1'b1, 16'h00FF);
        op16("inc_0101", 4'b0101, 3'd1, 16'h0000, 1'b0, 0, 1'b1, 16'h0100);
        @(negedge Clock);
        OutASel = 2'd2;
        OutBSel = 2'd3;
        #1;
        check_eq("dual_read.A2", {16'h0, OutA}, 32'h0100);
        check_eq("dual_read.B3", {16'h0, OutB}, 32'h00FF);
        for (int k = 0; k < 4; k++) push16("bank", k);
        drain();

        // Increment wrap on R2, flag survives later dec/load
        op16("r2_ffff", 4'b0100, 3'd2, 16'hFFFF, 1'b0, 2, 1'b1, 16'hFFFF);
        op16("r2_inc_wrap", 4'b0100, 3'd1, 16'h0000, 1'b0, 2, 1'b1, 16'h0000);
        check_eq("r2_inc_wrap.flag", {31'h0, Wrap[2]}, 32'h1);
        op16("r2_dec", 4'b0100, 3'd0, 16'h0000, 1'b0, 2, 1'b1, 16'hFFFF);
        op16("r2_load", 4'b0100, 3'd2, 16'h5A5A, 1'b0, 2, 1'b1, 16'h5A5A);
        check_eq("r2_sticky", {31'h0, Wrap[2]}, 32'h1);

        // Reset overrides an increment burst
        op16("r3_fffe", 4'b1000, 3'd2, 16'hFFFE, 1'b0, 3, 1'b1, 16'hFFFE);
        op16("r3_inc1", 4'b1000, 3'd1, 16'h0000, 1'b0, 3, 1'b1, 16'hFFFF);
        op16("r3_inc_rst", 4'b1000, 3'd1, 16'h0000, 1'b1, 3, 1'b1, 16'h0000);
        check_eq("r3_inc_rst.nowrap", {31'h0, Wrap[3]}, 32'h0);
        op16("r3_resume", 4'b1000, 3'd1, 16'h0000, 1'b0, 3, 1'b1, 16'h0001);

        // Random operations against the model
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  re;
            logic [2:0]  rfs;
            logic [15:0] ri;
            re  = 4'($urandom_range(0, 15));
            rfs = 3'($urandom_range(0, 7));
            ri  = 16'($urandom);
            op16("rand", re, rfs, ri, ($urandom_range(0, 19) == 0), $urandom_range(0, 3),
                 1'b0, 16'h0000);
        end

        // 8-bit, 8-register instance (HALF = 4)
        @(negedge Clock);
        reset8 = 1'b0;
        push8("w8_reset", 0, 8'h00, 8'h00, 8'hFF);
        push8("w8_reset", 7, 8'h00, 8'h00, 8'hFF);
        drain();
        op8("w8_sext_pos", 8'h20, 3'd7, 8'h85, 1'b0, 5, 8'h05, 8'h00, 8'hDF);
        op8("w8_whi",      8'h20, 3'd6, 8'h03, 1'b0, 5, 8'h35, 8'h00, 8'hDF);
        op8("w8_sext_neg", 8'h20, 3'd7, 8'h0A, 1'b0, 5, 8'hFA, 8'h00, 8'hDF);
        op8("w8_clr",      8'h20, 3'd3, 8'h00, 1'b0, 5, 8'h00, 8'h00, 8'hFF);
        op8("w8_dec_wrap", 8'h20, 3'd0, 8'h00, 1'b0, 5, 8'hFF, 8'h20, 8'hDF);
        op8("w8_r7_load",  8'h80, 3'd2, 8'hFF, 1'b0, 7, 8'hFF, 8'h20, 8'h5F);
        op8("w8_r7_inc",   8'h80, 3'd1, 8'h00, 1'b0, 7, 8'h00, 8'hA0, 8'hDF);
        op8("w8_wlo_clr",  8'h20, 3'd4, 8'h9C, 1'b0, 5, 8'h0C, 8'hA0, 8'hDF);
        op8("w8_whi2",     8'h20, 3'd6, 8'hAB, 1'b0, 5, 8'hBC, 8'hA0, 8'hDF);
        op8("w8_wlo",      8'h20, 3'd5, 8'h31, 1'b0, 5, 8'hB1, 8'hA0, 8'hDF);
        op8("w8_load_all", 8'hFF, 3'd2, 8'h11, 1'b0, 0, 8'h11, 8'hA0, 8'h00);
        op8("w8_rst_burst", 8'hFF, 3'd1, 8'h00, 1'b1, 6, 8'h00, 8'h00, 8'hFF);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
